// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared constants, state encodings and helpers for the LCD driver
// Contents:
//   ST_*                 FSM state encodings (3-bit)
//   LCD_*_BIT            bit positions inside the 32-bit LCD register
//   INIT_ROM / INIT_LEN  power-up command sequence (LCD_INIT_EN builds only)
//   is_clear_home()      selects the long post-transfer wait
package lcd_pkg;

    localparam logic [2:0] ST_PWRUP     = 3'd0;
    localparam logic [2:0] ST_INIT_LOAD = 3'd1;
    localparam logic [2:0] ST_IDLE      = 3'd2;
    localparam logic [2:0] ST_SETUP     = 3'd3;
    localparam logic [2:0] ST_PULSE     = 3'd4;
    localparam logic [2:0] ST_HOLD      = 3'd5;
    localparam logic [2:0] ST_WAIT      = 3'd6;

    localparam int LCD_ON_BIT  = 31;
    localparam int LCD_REQ_BIT = 9;
    localparam int LCD_RS_BIT  = 8;

`ifdef LCD_INIT_EN
    // 8-bit/2-line function set (x3), display on, clear, entry mode increment
    localparam int INIT_LEN = 6;
    localparam logic [7:0] INIT_ROM [INIT_LEN] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
`endif

    // Clear display (0x01) and return home (0x02/0x03) need the long panel wait
    function automatic logic is_clear_home(input logic rs, input logic [7:0] b);
        return (!rs) && ((b == 8'h01) || (b == 8'h02) || (b == 8'h03));
    endfunction

endpackage

// File: rtl/lcd_if.sv
// rtl/lcd_if.sv - LCD register / panel signal bundle
// Signals:
//   lcd_reg_i   32  LCD register from the core ([31] ON, [9] REQ, [8] RS, [7:0] byte)
//   lcd_data_o   8  panel data bus
//   lcd_rs_o     1  register select
//   lcd_rw_o     1  read/write (always write)
//   lcd_en_o     1  enable strobe
//   lcd_on_o     1  panel power/backlight
//   busy_o       1  transfer or init in progress
//   ack_o        1  last accepted REQ value
// Modports: master (core/bench side), slave (lcd_driver)
interface lcd_if;
    logic [31:0] lcd_reg_i;
    logic [7:0]  lcd_data_o;
    logic        lcd_rs_o;
    logic        lcd_rw_o;
    logic        lcd_en_o;
    logic        lcd_on_o;
    logic        busy_o;
    logic        ack_o;

    modport master (
        output lcd_reg_i,
        input  lcd_data_o, lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_on_o, busy_o, ack_o
    );

    modport slave (
        input  lcd_reg_i,
        output lcd_data_o, lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_on_o, busy_o, ack_o
    );
endinterface

// File: rtl/lcd_timer.sv
// rtl/lcd_timer.sv - loadable down-counter shared by all timed LCD states
// Ports:
//   clk_i    in   clock
//   load_i   in   load value_i into the counter this edge
//   value_i  in   W  reload value (phase length minus one)
//   done_o   out  counter has reached zero
// Loading N gives N+1 cycles until the owning state sees done_o.
module lcd_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         done_o
);

    logic [W-1:0] r_cnt;

    // No reset: the driver asserts load_i throughout its reset
    always_ff @(posedge clk_i) begin
        if (load_i) begin
            r_cnt <= value_i;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign done_o = (r_cnt == '0);

endmodule

// File: rtl/lcd_driver.sv
// rtl/lcd_driver.sv - HD44780 panel engine behind the memory-mapped LCD register
// Ports:
//   clk_i  in  clock (core domain)
//   rst_i  in  synchronous reset, active-high
//   bus    lcd_if.slave  register input, panel outputs, busy/ack status
// Optional feature: LCD_INIT_EN adds the power-up wait and init command sequence.
// A request is pending while lcd_reg_i[9] differs from ack_o; it is only
// accepted in IDLE, so toggles made while busy are sampled when IDLE returns.
module lcd_driver
    import lcd_pkg::*;
#(
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 12,
    parameter int T_HOLD  = 2,
    parameter int T_CMD   = 2000,
    parameter int T_CLR   = 82000,
    parameter int T_PWRUP = 750000
) (
    input  logic   clk_i,
    input  logic   rst_i,
    lcd_if.slave   bus
);

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_MAX = imax(imax(imax(T_SETUP, T_PULSE), imax(T_HOLD, T_CMD)),
                                imax(T_CLR, T_PWRUP));
    localparam int TW    = $clog2(T_MAX + 1);

    // Timer reload values: a phase of T cycles loads T-1
    localparam logic [TW-1:0] V_SETUP = TW'(T_SETUP - 1);
    localparam logic [TW-1:0] V_PULSE = TW'(T_PULSE - 1);
    localparam logic [TW-1:0] V_HOLD  = TW'(T_HOLD - 1);
    localparam logic [TW-1:0] V_CMD   = TW'(T_CMD - 1);
    localparam logic [TW-1:0] V_CLR   = TW'(T_CLR - 1);
`ifdef LCD_INIT_EN
    localparam logic [TW-1:0] V_PWRUP = TW'(T_PWRUP - 1);
`endif

    logic [2:0]    r_state;
    logic [7:0]    r_data;
    logic          r_rs;
    logic          r_ack;
    logic          r_on;
    logic          w_pending;
    logic          w_load;
    logic [TW-1:0] w_value;
    logic [TW-1:0] w_wait_val;
    logic          w_done;
    logic          w_unused_reg;

`ifdef LCD_INIT_EN
    logic [2:0]    r_init_idx;   // next ROM entry to send
    logic          w_init_busy;
    assign w_init_busy = (r_init_idx != 3'(INIT_LEN));
`endif

    assign w_pending    = (bus.lcd_reg_i[LCD_REQ_BIT] != r_ack);
    assign w_wait_val   = is_clear_home(r_rs, r_data) ? V_CLR : V_CMD;
    assign w_unused_reg = ^bus.lcd_reg_i[30:10];

    lcd_timer #(.W(TW)) u_timer (
        .clk_i   (clk_i),
        .load_i  (w_load),
        .value_i (w_value),
        .done_o  (w_done)
    );

    // Timer is reloaded on every state transition with the next phase length
    always_comb begin
        w_load  = 1'b0;
        w_value = '0;
        if (rst_i) begin
            w_load = 1'b1;
`ifdef LCD_INIT_EN
            w_value = V_PWRUP;
`endif
        end else begin
            case (r_state)
`ifdef LCD_INIT_EN
                ST_PWRUP: begin
                    if (w_done) begin
                        w_load  = 1'b1;
                        w_value = V_SETUP;
                    end
                end
`endif
                ST_IDLE: begin
                    if (w_pending) begin
                        w_load  = 1'b1;
                        w_value = V_SETUP;
                    end
                end
`ifdef LCD_INIT_EN
                ST_INIT_LOAD,
`endif
                ST_SETUP: begin
                    if (w_done) begin
                        w_load  = 1'b1;
                        w_value = V_PULSE;
                    end
                end
                ST_PULSE: begin
                    if (w_done) begin
                        w_load  = 1'b1;
                        w_value = V_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_done) begin
                        w_load  = 1'b1;
                        w_value = w_wait_val;
                    end
                end
                ST_WAIT: begin
`ifdef LCD_INIT_EN
                    if (w_done && w_init_busy) begin
                        w_load  = 1'b1;
                        w_value = V_SETUP;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data <= 8'h00;
            r_rs   <= 1'b0;
            r_ack  <= 1'b0;
            r_on   <= 1'b0;
`ifdef LCD_INIT_EN
            r_state    <= ST_PWRUP;
            r_init_idx <= 3'd0;
`else
            r_state <= ST_IDLE;
`endif
        end else begin
            r_on <= bus.lcd_reg_i[LCD_ON_BIT];
            case (r_state)
`ifdef LCD_INIT_EN
                // INIT_LOAD captures a ROM byte on entry and then doubles as
                // that byte's setup phase, so init bytes cost the same as user bytes
                ST_PWRUP: begin
                    if (w_done) begin
                        r_data     <= INIT_ROM[0];
                        r_rs       <= 1'b0;
                        r_init_idx <= 3'd1;
                        r_state    <= ST_INIT_LOAD;
                    end
                end
                ST_INIT_LOAD: begin
                    if (w_done) r_state <= ST_PULSE;
                end
`endif
                ST_IDLE: begin
                    if (w_pending) begin
                        r_data  <= bus.lcd_reg_i[7:0];
                        r_rs    <= bus.lcd_reg_i[LCD_RS_BIT];
                        r_ack   <= bus.lcd_reg_i[LCD_REQ_BIT];
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (w_done) r_state <= ST_PULSE;
                end
                ST_PULSE: begin
                    if (w_done) r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (w_done) r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_done) begin
`ifdef LCD_INIT_EN
                        if (w_init_busy) begin
                            r_data     <= INIT_ROM[r_init_idx];
                            r_rs       <= 1'b0;
                            r_init_idx <= r_init_idx + 3'd1;
                            r_state    <= ST_INIT_LOAD;
                        end else begin
                            r_state <= ST_IDLE;
                        end
`else
                        r_state <= ST_IDLE;
`endif
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // EN decoded from the registered state: a reset during PULSE drops it next edge
    assign bus.lcd_data_o = r_data;
    assign bus.lcd_rs_o   = r_rs;
    assign bus.lcd_rw_o   = 1'b0;
    assign bus.lcd_en_o   = (r_state == ST_PULSE);
    assign bus.lcd_on_o   = r_on;
    assign bus.busy_o     = (r_state != ST_IDLE);
    assign bus.ack_o      = r_ack;

endmodule

// File: tb/tb_lcd_driver.sv
// tb/tb_lcd_driver.sv - directed self-checking bench for lcd_driver
module tb_lcd_driver;

    logic clk   = 1'b0;
    logic rst_i = 1'b1;

    lcd_if u_if ();

    lcd_driver #(
        .T_SETUP (2),
        .T_PULSE (4),
        .T_HOLD  (2),
        .T_CMD   (10),
        .T_CLR   (30),
        .T_PWRUP (50)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (u_if.slave)
    );

    always #5 clk = ~clk;

`ifdef LCD_INIT_EN
    localparam logic EXP_BUSY_RST = 1'b1;
`else
    localparam logic EXP_BUSY_RST = 1'b0;
`endif

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Sample buffer: entry k holds outputs seen k cycles after capture start
    logic       s_busy [0:127];
    logic       s_en   [0:127];
    logic       s_rs   [0:127];
    logic       s_ack  [0:127];
    logic       s_on   [0:127];
    logic [7:0] s_data [0:127];
    int         cap_n;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cap_clear();
        cap_n     = 0;
        s_en[0]   = 1'b0;
        s_busy[0] = 1'b0;
    endtask

    task automatic cap(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (cap_n < 127) begin
                cap_n++;
                s_busy[cap_n] = u_if.busy_o;
                s_en[cap_n]   = u_if.lcd_en_o;
                s_rs[cap_n]   = u_if.lcd_rs_o;
                s_ack[cap_n]  = u_if.ack_o;
                s_on[cap_n]   = u_if.lcd_on_o;
                s_data[cap_n] = u_if.lcd_data_o;
            end
        end
    endtask

    function automatic int busy_run();
        int r = 0;
        for (int k = 1; k <= cap_n; k++) begin
            if (!s_busy[k]) break;
            r++;
        end
        return r;
    endfunction

    function automatic int busy_total();
        int r = 0;
        for (int k = 1; k <= cap_n; k++) if (s_busy[k]) r++;
        return r;
    endfunction

    function automatic int en_first();
        for (int k = 1; k <= cap_n; k++) if (s_en[k]) return k;
        return 0;
    endfunction

    function automatic int en_total();
        int r = 0;
        for (int k = 1; k <= cap_n; k++) if (s_en[k]) r++;
        return r;
    endfunction

    function automatic int en_rises();
        int r = 0;
        for (int k = 1; k <= cap_n; k++) if (s_en[k] && !s_en[k-1]) r++;
        return r;
    endfunction

`ifdef LCD_INIT_EN
    logic [7:0] init_exp [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    logic [7:0] init_got [6];
`endif

    initial begin
        u_if.lcd_reg_i = 32'h0;
        rst_i = 1'b1;
        repeat (3) tick();

        check("rst_data", 32'(u_if.lcd_data_o), 32'h00);
        check("rst_rs",   32'(u_if.lcd_rs_o),   32'h0);
        check("rst_rw",   32'(u_if.lcd_rw_o),   32'h0);
        check("rst_en",   32'(u_if.lcd_en_o),   32'h0);
        check("rst_on",   32'(u_if.lcd_on_o),   32'h0);
        check("rst_ack",  32'(u_if.ack_o),      32'h0);
        check("rst_busy", 32'(u_if.busy_o),     32'(EXP_BUSY_RST));

`ifdef LCD_INIT_EN
        begin
            int   k      = 0;
            int   pulses = 0;
            logic prev   = 1'b0;
            rst_i = 1'b0;
            while (u_if.busy_o && k < 400) begin
                tick();
                k++;
                if (u_if.lcd_en_o && !prev) begin
                    if (pulses < 6) init_got[pulses] = u_if.lcd_data_o;
                    pulses++;
                end
                prev = u_if.lcd_en_o;
            end
            check("init_busy_cycles", 32'(k), 32'd178);
            check("init_pulses", 32'(pulses), 32'd6);
            for (int i = 0; i < 6; i++)
                check($sformatf("init_byte%0d", i), 32'(init_got[i]), 32'(init_exp[i]));
        end
`else
        rst_i = 1'b0;
        tick();
`endif
        check("idle_busy", 32'(u_if.busy_o), 32'h0);

        // 1: plain command byte 0x41
        cap_clear();
        u_if.lcd_reg_i = 32'h0000_0241;
        cap(25);
        check("t1_data",     32'(s_data[1]),   32'h41);
        check("t1_rs",       32'(s_rs[1]),     32'h0);
        check("t1_ack",      32'(s_ack[1]),    32'h1);
        check("t1_en_first", 32'(en_first()),  32'd3);
        check("t1_en_len",   32'(en_total()),  32'd4);
        check("t1_busy_len", 32'(busy_run()),  32'd18);
        check("t1_idle",     32'(s_busy[19]),  32'h0);

        // 2: clear display takes the long wait
        cap_clear();
        u_if.lcd_reg_i = 32'h0000_0001;
        cap(45);
        check("t2_ack",      32'(s_ack[1]),   32'h0);
        check("t2_data",     32'(s_data[1]),  32'h01);
        check("t2_busy_len", 32'(busy_run()), 32'd38);
        check("t2_en_len",   32'(en_total()), 32'd4);

        // 3: two toggles while busy cancel out
        cap_clear();
        u_if.lcd_reg_i = 32'h0000_0200;
        cap(5);
        u_if.lcd_reg_i = 32'h0000_0000;
        cap(4);
        u_if.lcd_reg_i = 32'h0000_0200;
        cap(40);
        check("t3_busy_len",   32'(busy_run()),   32'd18);
        check("t3_busy_total", 32'(busy_total()), 32'd18);
        check("t3_en_rises",   32'(en_rises()),   32'd1);
        check("t3_ack_end",    32'(s_ack[49]),    32'h1);
        check("t3_idle_end",   32'(s_busy[49]),   32'h0);

        // 4: one toggle while busy is served back-to-back with new contents
        cap_clear();
        u_if.lcd_reg_i = 32'h0000_0012;
        cap(3);
        u_if.lcd_reg_i = 32'h0000_0355;
        cap(40);
        check("t4_busy_len",  32'(busy_run()),  32'd18);
        check("t4_gap",       32'(s_busy[19]),  32'h0);
        check("t4_data_hold", 32'(s_data[19]),  32'h12);
        check("t4_restart",   32'(s_busy[20]),  32'h1);
        check("t4_data",      32'(s_data[20]),  32'h55);
        check("t4_rs",        32'(s_rs[20]),    32'h1);
        check("t4_ack",       32'(s_ack[20]),   32'h1);
        check("t4_busy2_end", 32'(s_busy[37]),  32'h1);
        check("t4_idle2",     32'(s_busy[38]),  32'h0);
        check("t4_en_rises",  32'(en_rises()),  32'd2);

        // 6: reset during PULSE, then ON tracking
        cap_clear();
        u_if.lcd_reg_i = 32'h8000_0155;
        cap(4);
        check("t6_in_pulse", 32'(s_en[4]), 32'h1);
        check("t6_on_set",   32'(s_on[4]), 32'h1);
        rst_i = 1'b1;
        tick();
        check("t6_en",   32'(u_if.lcd_en_o),   32'h0);
        check("t6_data", 32'(u_if.lcd_data_o), 32'h00);
        check("t6_rs",   32'(u_if.lcd_rs_o),   32'h0);
        check("t6_rw",   32'(u_if.lcd_rw_o),   32'h0);
        check("t6_ack",  32'(u_if.ack_o),      32'h0);
        check("t6_on",   32'(u_if.lcd_on_o),   32'h0);
        check("t6_busy", 32'(u_if.busy_o),     32'(EXP_BUSY_RST));
        u_if.lcd_reg_i = 32'h8000_0000;
        tick();
        check("t6_on_in_rst", 32'(u_if.lcd_on_o), 32'h0);
        rst_i = 1'b0;
        tick();
        check("t6_on_rise", 32'(u_if.lcd_on_o), 32'h1);
        u_if.lcd_reg_i = 32'h0000_0000;
        check("t6_on_latency", 32'(u_if.lcd_on_o), 32'h1);
        tick();
        check("t6_on_fall", 32'(u_if.lcd_on_o), 32'h0);
        check("t6_no_req_ack", 32'(u_if.ack_o), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
